pipe_stage_elastic: RTL

Parametrised elastic pipeline stage for the Y86-64 five-stage core; the generalised successor of the fixed F→D, D→E, E→M and M→W registers. It carries an arbitrary-width packed stage payload behind a valid/ready handshake with a two-entry skid buffer, so `up_ready_o` depends only on flops. It keeps the legacy stall/bubble hazard controls and adds saturating stall and bubble event counters for the performance monitor.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/sat_counter.sv | 19 +
 rtl/pipe_stage_elastic.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the Y86-64 elastic pipeline stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pse_state_t;

  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;

  localparam int F2D_W = 211;

  typedef struct packed {
    logic [2:0]  stat;
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } f2d_t;

  // A squashed fetch looks like a nop with no register traffic.
  localparam logic [F2D_W-1:0] F2D_BUBBLE =
    {SAOK, 64'd0, INOP, 4'd0, RNONE, RNONE, 64'd0, 64'd0};

  function automatic logic [F2D_W-1:0] f2d_pack(input f2d_t b);
    return b;
  endfunction

  function automatic f2d_t f2d_unpack(input logic [F2D_W-1:0] v);
    return f2d_t'(v);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a two-entry skid buffer, legacy stall/bubble
// controls and saturating hazard event counters.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = F2D_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = F2D_BUBBLE,
  parameter int                CNT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  input  logic              stall_i,
  input  logic              bubble_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  pse_state_t        state, state_nxt;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              up_fire, dn_fire;
  logic              main_ld, main_from_skid, skid_ld;

  // Handshake outputs decode from the state register only.
  assign up_ready_o = (state != SKID);
  assign dn_valid_o = (state != EMPTY);
  assign occ_o      = 2'(state);
  assign dn_data_o  = dn_valid_o ? main_q : BUBBLE_VAL;

  assign up_fire = up_valid_i & up_ready_o;
  assign dn_fire = dn_valid_o & dn_ready_i & ~stall_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (bubble_i) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (up_fire) begin
          state_nxt = FULL;
          main_ld   = 1'b1;
        end
        FULL: begin
          if (dn_fire && up_fire) begin
            main_ld = 1'b1;
          end else if (dn_fire) begin
            state_nxt = EMPTY;
          end else if (up_fire) begin
            state_nxt = SKID;
            skid_ld   = 1'b1;
          end
        end
        SKID: if (dn_fire) begin
          state_nxt      = FULL;
          main_from_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_q <= BUBBLE_VAL;
      skid_q <= '0;
    end else begin
      if (bubble_i)            main_q <= BUBBLE_VAL;
      else if (main_ld)        main_q <= up_data_i;
      else if (main_from_skid) main_q <= skid_q;
      if (skid_ld)             skid_q <= up_data_i;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .inc   (stall_i & ~bubble_i & dn_valid_o),
    .count (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .inc   (bubble_i),
    .count (bubble_cnt_o)
  );

endmodule
